// File: rtl/madd_share_ctrl.sv
// madd_share_ctrl
// Time-shares one combinational approximate multiply-add datapath among
// N_REQ requesters. A round-robin arbiter accepts one operand, the operand is
// held on dp_in for a settle cycle, and the approximate result is captured.
// The result is compared with the exact a*b+c and returned with the requester
// ID and an error flag. Saturating error statistics are kept for run-time
// characterisation of the approximation.

module madd_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int ET    = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [6*N_REQ-1:0]   req_opnd,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [3:0]           rsp_data,
    output logic                 rsp_err,
    output logic [5:0]           dp_in,
    input  logic [3:0]           dp_out,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [3:0]           err_max
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    // Exact reference result: a*b + c with a=op[1:0], b=op[3:2], c=op[5:4].
    function automatic logic [3:0] exact_madd(input logic [5:0] op);
        return ({2'b00, op[1:0]} * {2'b00, op[3:2]}) + {2'b00, op[5:4]};
    endfunction

    // |approx - exact| formed at 5 bits, clamped to the 4-bit statistic range.
    function automatic logic [3:0] abs_diff_clamp(input logic [3:0] approx,
                                                  input logic [3:0] exact);
        logic [4:0] d;
        if (approx >= exact) begin
            d = {1'b0, approx} - {1'b0, exact};
        end else begin
            d = {1'b0, exact} - {1'b0, approx};
        end
        if (d > 5'd15) begin
            return 4'd15;
        end
        return d[3:0];
    endfunction

    // Error counter sticks at its all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [2:0]       last_q, last_d;
    logic [2:0]       id_q, id_d;
    logic [3:0]       data_q, data_d;
    logic             err_q, err_d;
    logic [5:0]       dp_q, dp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       max_q, max_d;

    logic             grant_hit;
    logic [2:0]       grant_idx;
    logic [5:0]       grant_opnd;
    logic [3:0]       exact_now;
    logic [3:0]       absd_now;
    logic             err_now;

    // Round-robin pick: first asserted request strictly after last_q, wrapping.
    always_comb begin
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        int                 off;
        dbl       = {req_valid, req_valid};
        rot       = N_REQ'(dbl >> (int'(last_q) + 1));
        off       = 0;
        grant_hit = |req_valid;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
            end
        end
        grant_idx  = 3'((int'(last_q) + 1 + off) % N_REQ);
        grant_opnd = 6'(req_opnd >> (6 * int'(grant_idx)));
    end

    // Compare the datapath result against the exact value.
    always_comb begin
        exact_now = exact_madd(dp_q);
        absd_now  = abs_diff_clamp(dp_out, exact_now);
        err_now   = int'(absd_now) > ET;
    end

    // Grant is visible only while idle and out of reset; response valid in RESP.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_hit && !rst) begin
            req_ready = N_REQ'(1) << grant_idx;
        end
        rsp_valid = (state_q == S_RESP);
        rsp_id    = id_q;
        rsp_data  = data_q;
        rsp_err   = err_q;
        dp_in     = dp_q;
        err_cnt   = cnt_q;
        err_max   = max_q;
    end

    // Transaction sequencing and statistics next-state.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        dp_d    = dp_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        case (state_q)
            S_IDLE: begin
                if (grant_hit) begin
                    dp_d    = grant_opnd;
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // dp_in settles on the shared datapath for one cycle.
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d = dp_out;
                err_d  = err_now;
                if (err_now) begin
                    cnt_d = sat_inc(cnt_q);
                end
                if (absd_now > max_q) begin
                    max_d = absd_now;
                end
                state_d = S_RESP;
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        // A clear wins over, and discards, a same-cycle capture update.
        if (clr_stats) begin
            cnt_d = '0;
            max_d = '0;
        end
    end

    // State registers; reset aborts any transaction and restarts at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 3'(N_REQ - 1);
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            dp_q    <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
            dp_q    <= dp_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
        end
    end

endmodule

// File: doc/madd_share_ctrl.md
# madd_share_ctrl

Sequential controller that time-shares one combinational approximate multiply-add datapath (6 operand bits in, 4 result bits out) among several requesters. It arbitrates requests round-robin, holds the operand stable on the datapath, captures the approximate result, checks it against an internally computed exact result, and returns it tagged with requester ID and an error-threshold flag. It sits between the requester fabric and the approximate madd instance and accumulates error statistics for characterising the approximation at run time.

## Interface

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ET, 1, error threshold; a result is in error when |approx − exact| > ET
- CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request
- req_ready  out  N_REQ  one-hot grant/accept; handshake completes when valid & ready
- req_opnd  in  6*N_REQ  operand of requester i at bits [6i+5:6i]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  3  requester index of the response
- rsp_data  out  4  captured approximate result
- rsp_err  out  1  |rsp_data − exact| > ET
- dp_in  out  6  registered operand driven to the shared datapath
- dp_out  in  4  combinational result from the shared datapath
- clr_stats  in  1  synchronous clear of err_cnt and err_max
- err_cnt  out  CNT_W  saturating count of responses with rsp_err = 1
- err_max  out  4  largest |approx − exact| seen since reset or clear

## Operation

- Operand fields: a = opnd[1:0], b = opnd[3:2], c = opnd[5:4]. Exact result = a*b + c, range 0..12, 4 bits unsigned.
- Abs diff = |dp_out − exact|, computed at 5 bits, clamped to 4 bits (max 15).
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if any req_valid, pick the first asserted index after last_grant, wrapping mod N_REQ. Assert req_ready[i] combinationally in that cycle only. Latch req_opnd[i] into dp_in and i into rsp_id, set last_grant = i, go to ISSUE. If no request, stay in IDLE.
  - ISSUE: dp_in is held for one settle cycle. Go to CAPTURE.
  - CAPTURE: register dp_out into rsp_data. Register rsp_err and update the statistics. Go to RESP.
  - RESP: rsp_valid = 1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready. When rsp_valid & rsp_ready, go to IDLE.
- req_ready is 0 in every state except IDLE. At most one bit of req_ready is set at a time.
- dp_in changes only on acceptance in IDLE and holds its value between transactions.
- Statistics, updated in CAPTURE:
  - err_cnt increments by 1 when rsp_err and saturates at 2^CNT_W − 1.
  - err_max = max(err_max, abs diff).
- clr_stats sets err_cnt and err_max to 0 on the next edge. It has priority over a same-cycle CAPTURE update, and that update is dropped.

## Timing

- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, dp_in 0, err_cnt 0, err_max 0.
- last_grant resets to N_REQ−1, so requester 0 wins the first arbitration.
- Accept at edge T, where req_valid & req_ready are sampled. dp_in is valid after T. CAPTURE samples dp_out at T+2. rsp_valid is high from T+3.
- Minimum spacing between acceptances is 4 cycles, with rsp_ready held high.
- Backpressure: with rsp_ready low, RESP holds indefinitely and no new request is accepted.
- A requester deasserting req_valid while not granted is legal and is ignored.
- Reset asserted mid-transaction aborts it immediately. No response is produced, statistics clear, and arbitration restarts at requester 0.
- dp_out is sampled only in CAPTURE. Glitches in other cycles have no effect.

## Test plan

- Single request: requester 2 sends opnd = 6'b111111 (a=3, b=3, c=3, exact 12) and the stub returns 12. Required: req_ready = 0100 in the acceptance cycle; three cycles later rsp_valid = 1, rsp_id = 2, rsp_data = 12, rsp_err = 0, err_cnt = 0.
- Threshold: opnd = 6'b010110 (a=2, b=1, c=1, exact 3). A stub returning 4 gives rsp_err = 0 and err_max = 1. A stub returning 5 gives rsp_err = 1, err_cnt = 1 and err_max = 2.
- Round-robin: all four req_valid held high. Grants must occur in order 0, 1, 2, 3, 0, each 4 cycles apart with rsp_ready = 1, and rsp_id must follow the same sequence.
- Backpressure: hold rsp_ready = 0 for 10 cycles in RESP. rsp_valid, rsp_id and rsp_data stay stable, req_ready stays 0, and the next grant comes 1 cycle after rsp_ready rises.
- Saturation and clear: with CNT_W = 2, six erroneous results give err_cnt = 3. clr_stats in the same cycle as a CAPTURE of an erroneous result gives err_cnt = 0 and err_max = 0.
- Reset mid-operation: assert rst in ISSUE. All outputs return to their reset values, no rsp_valid follows, and with requesters 1 and 0 then pending, requester 0 is granted first.
